muldiv_unit: RTL

- Iterative multiply/divide unit with architectural HI/LO registers. It replaces the single-cycle combinational 64-bit multiply/divide path in the CPU datapath.
- Supports signed/unsigned MULT and DIV at parametrised width, one bit per cycle.
- Uses a start/busy/done handshake so the pipeline stalls on HI/LO reads while an operation is in flight.
- Also provides direct HI/LO writes (MTHI/MTLO) and a flush input for exception/branch cancellation.

---
 rtl/muldiv_unit.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/muldiv_unit.sv
// Iterative signed/unsigned multiply/divide unit with architectural HI/LO registers.
// Operations take one bit per cycle; results land in HI/LO in FIX and are signalled by a one-cycle done pulse.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_start,
   input  logic [1:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   input  logic             i_flush,
   input  logic             i_hi_we,
   input  logic             i_lo_we,
   input  logic [WIDTH-1:0] i_wdata,
   output logic             o_busy,
   output logic             o_done,
   output logic [WIDTH-1:0] o_hi,
   output logic [WIDTH-1:0] o_lo,
   output logic             o_div_zero
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_FIX  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t r_state, w_state_nxt;

   logic [CNT_W-1:0]   r_cnt;
   logic [1:0]         r_op;
   logic [WIDTH-1:0]   r_a;
   logic [WIDTH-1:0]   r_opnd;
   logic [2*WIDTH-1:0] r_acc;
   logic               r_neg_q;
   logic               r_neg_r;
   logic               r_bzero;
   logic [WIDTH-1:0]   r_hi;
   logic [WIDTH-1:0]   r_lo;
   logic               r_dz;

   logic               w_accept;
   logic               w_iter;
   logic               w_fix_wr;
   logic               w_wr_ok;
   logic               w_sgn;
   logic [WIDTH-1:0]   w_mag_a;
   logic [WIDTH-1:0]   w_mag_b;
   logic [WIDTH:0]     w_msum;
   logic [2*WIDTH-1:0] w_mul_nxt;
   logic [WIDTH:0]     w_cand;
   logic [WIDTH+1:0]   w_dsub;
   logic [2*WIDTH-1:0] w_div_nxt;
   logic [2*WIDTH-1:0] w_prod;
   logic [WIDTH-1:0]   w_quo;
   logic [WIDTH-1:0]   w_rem;

   assign w_accept = (r_state == ST_IDLE) && i_start && !i_flush;
   assign w_iter   = (r_state == ST_RUN) && !i_flush;
   assign w_fix_wr = (r_state == ST_FIX) && !i_flush;
   // An accepted start takes priority over a same-cycle MTHI/MTLO.
   assign w_wr_ok  = ((r_state == ST_IDLE) && !w_accept) || (r_state == ST_DONE);

   // Operand magnitudes; op[0]=0 selects the signed variants.
   assign w_sgn   = ~i_op[0];
   assign w_mag_a = (w_sgn && i_a[WIDTH-1]) ? -i_a : i_a;
   assign w_mag_b = (w_sgn && i_b[WIDTH-1]) ? -i_b : i_b;

   // Shift-add: upper half accumulates the multiplicand, multiplier shifts out the bottom.
   assign w_msum    = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opnd};
   assign w_mul_nxt = r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:1]};

   // Restoring divide: remainder in the upper half, quotient bits shift into the lower half.
   assign w_cand    = r_acc[2*WIDTH-1:WIDTH-1];
   assign w_dsub    = {1'b0, w_cand} - {2'b00, r_opnd};
   assign w_div_nxt = w_dsub[WIDTH+1] ? {w_cand[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                                      : {w_dsub[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1};

   assign w_prod = r_neg_q ? -r_acc : r_acc;
   assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
   assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: if (w_accept) w_state_nxt = ST_RUN;
         ST_RUN: begin
            if (i_flush)                    w_state_nxt = ST_IDLE;
            else if (r_cnt == CNT_W'(1))    w_state_nxt = ST_FIX;
         end
         ST_FIX:  w_state_nxt = i_flush ? ST_IDLE : ST_DONE;
         ST_DONE: w_state_nxt = ST_IDLE;
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_cnt   <= '0;
         r_op    <= '0;
         r_a     <= '0;
         r_opnd  <= '0;
         r_acc   <= '0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_bzero <= 1'b0;
      end else if (w_accept) begin
         r_cnt   <= CNT_W'(WIDTH);
         r_op    <= i_op;
         r_a     <= i_a;
         r_opnd  <= i_op[1] ? w_mag_b : w_mag_a;
         r_acc   <= {{WIDTH{1'b0}}, (i_op[1] ? w_mag_a : w_mag_b)};
         r_neg_q <= w_sgn && (i_a[WIDTH-1] ^ i_b[WIDTH-1]);
         r_neg_r <= w_sgn && i_a[WIDTH-1];
         r_bzero <= (i_b == '0);
      end else if (w_iter) begin
         r_cnt <= r_cnt - CNT_W'(1);
         r_acc <= r_op[1] ? w_div_nxt : w_mul_nxt;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_hi <= '0;
         r_lo <= '0;
         r_dz <= 1'b0;
      end else begin
         if (w_accept) r_dz <= 1'b0;
         if (w_fix_wr) begin
            if (!r_op[1]) begin
               r_hi <= w_prod[2*WIDTH-1:WIDTH];
               r_lo <= w_prod[WIDTH-1:0];
            end else if (r_bzero) begin
               r_hi <= r_a;
               r_lo <= '1;
               r_dz <= 1'b1;
            end else begin
               r_hi <= w_rem;
               r_lo <= w_quo;
            end
         end else if (w_wr_ok) begin
            if (i_hi_we) r_hi <= i_wdata;
            if (i_lo_we) r_lo <= i_wdata;
         end
      end
   end

   assign o_busy     = (r_state == ST_RUN) || (r_state == ST_FIX);
   assign o_done     = (r_state == ST_DONE);
   assign o_hi       = r_hi;
   assign o_lo       = r_lo;
   assign o_div_zero = r_dz;

endmodule
